output_writeback: RTL and testbench

Write-back sequencer at the far end of the datapath. It accepts per-lane results from the processing units (one beat of `NUM_UNITS` values at a time) and turns them into lane-parallel writes to the image memory, laid out in raster order over the valid-convolution output frame. The frame is (IMAGE_WIDTH−k+1)×(IMAGE_HEIGHT−k+1). A 2-entry buffer absorbs memory stalls, with valid/ready backpressure toward the producers.

---
 rtl/output_writeback.sv | 190 +++++++++++++++++++
 tb/tb_output_writeback.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_writeback.sv
// Purpose : write-back sequencer; turns NUM_UNITS-lane result beats into raster-order
//           lane-parallel image-memory writes over the valid-convolution output frame.
// Latency : beat accepted at cycle t -> earliest write at t+1; 1 beat/cycle sustained.
// Backpressure: 2-entry buffer absorbs mem_stall; in_ready=0 whenever the buffer is full.
//
// Ports:
//   clk, reset (sync, active-low)
//   start/kernel_dim/base_addr/relu_en : frame setup, sampled in IDLE only
//   en_in/data_in/in_ready             : beat valid/ready from the processing units
//   mem_stall                          : memory cannot accept a write this cycle
//   wr_en/wr_mask/wr_addr/wr_data      : lane-parallel write port
//   busy, done                         : frame status (busy in RUN/DRAIN, done one-cycle pulse)
module output_writeback #(
    parameter  int DATA_WIDTH   = 16,
    parameter  int IMAGE_WIDTH  = 8,
    parameter  int IMAGE_HEIGHT = 8,
    parameter  int NUM_UNITS    = 2,
    localparam int AW           = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT),
    localparam int KW           = $clog2(IMAGE_WIDTH)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [KW-1:0]                         kernel_dim,
    input  logic [AW-1:0]                         base_addr,
    input  logic                                  relu_en,
    input  logic                                  en_in,
    input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  data_in,
    output logic                                  in_ready,
    input  logic                                  mem_stall,
    output logic                                  wr_en,
    output logic [NUM_UNITS-1:0]                  wr_mask,
    output logic [NUM_UNITS-1:0][AW-1:0]          wr_addr,
    output logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  wr_data,
    output logic                                  busy,
    output logic                                  done
);

    // Counter width: holds IMAGE_WIDTH*IMAGE_HEIGHT plus the overshoot of a final partial beat.
    localparam int CW = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT + NUM_UNITS) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic [NUM_UNITS-1:0]                  mask;
        logic [NUM_UNITS-1:0][AW-1:0]          addr;
        logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  data;
    } entry_t;

    state_t                                  state_q, state_d;
    logic [CW-1:0]                           idx_q, idx_d;
    logic [CW-1:0]                           total_q, total_d;
    logic [AW-1:0]                           base_q, base_d;
    logic                                    relu_q, relu_d;

    entry_t                                  buf_q [2];
    logic                                    wptr_q, rptr_q;
    logic [1:0]                              cnt_q, cnt_d;
    logic [NUM_UNITS-1:0][AW-1:0]            last_addr_q;
    logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]    last_data_q;

    logic [KW-1:0]                           k_eff;
    logic [CW-1:0]                           out_w, out_h, total_start;
    logic [CW-1:0]                           idx_inc;
    logic [CW-1:0]                           lane_idx;
    entry_t                                  push_entry;
    entry_t                                  head;
    logic                                    full, empty, push, pop;

    // Frame geometry from the live kernel_dim; only used on the start cycle.
    always_comb begin
        k_eff       = (kernel_dim == '0) ? KW'(1) : kernel_dim;
        out_w       = CW'(IMAGE_WIDTH)  - CW'(k_eff) + CW'(1);
        out_h       = CW'(IMAGE_HEIGHT) - CW'(k_eff) + CW'(1);
        total_start = out_w * out_h;
    end

    assign full  = (cnt_q == 2'd2);
    assign empty = (cnt_q == 2'd0);
    assign head  = buf_q[rptr_q];

    // Every output is forced quiet while reset is asserted, including the reset cycle itself.
    assign in_ready = reset && (state_q == S_RUN) && !full;
    assign push     = en_in && in_ready;
    assign wr_en    = reset && !empty && !mem_stall;
    assign pop      = wr_en;
    assign busy     = reset && ((state_q == S_RUN) || (state_q == S_DRAIN));
    assign done     = reset && (state_q == S_DONE);

    assign wr_mask  = wr_en ? head.mask : '0;
    assign wr_addr  = !reset ? '0 : (wr_en ? head.addr : last_addr_q);
    assign wr_data  = !reset ? '0 : (wr_en ? head.data : last_data_q);

    // Buffer entry for the beat being accepted this cycle.
    always_comb begin
        push_entry = '0;
        lane_idx   = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            lane_idx           = idx_q + CW'(i);
            push_entry.mask[i] = (lane_idx < total_q);
            push_entry.addr[i] = base_q + lane_idx[AW-1:0];
            push_entry.data[i] = (relu_q && data_in[i][DATA_WIDTH-1]) ? '0 : data_in[i];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        total_d = total_q;
        base_d  = base_q;
        relu_d  = relu_q;
        idx_inc = idx_q + CW'(NUM_UNITS);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    relu_d  = relu_en;
                    total_d = total_start;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (push) begin
                    idx_d = idx_inc;
                    if (idx_inc >= total_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Leave as soon as the last pending write is issued, not a cycle later.
                if (empty || ((cnt_q == 2'd1) && pop)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            total_q     <= '0;
            base_q      <= '0;
            relu_q      <= 1'b0;
            wptr_q      <= 1'b0;
            rptr_q      <= 1'b0;
            cnt_q       <= 2'd0;
            last_addr_q <= '0;
            last_data_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            total_q <= total_d;
            base_q  <= base_d;
            relu_q  <= relu_d;
            cnt_q   <= cnt_d;
            if (push) begin
                wptr_q <= ~wptr_q;
            end
            if (pop) begin
                rptr_q      <= ~rptr_q;
                last_addr_q <= head.addr;
                last_data_q <= head.data;
            end
        end
    end

    // Payload storage needs no reset: it is only observed through valid entries.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[wptr_q] <= push_entry;
        end
    end

endmodule

// File: tb/tb_output_writeback.sv
module tb_output_writeback;
    localparam int DW = 16;
    localparam int IW = 8;
    localparam int IH = 8;
    localparam int NU = 2;
    localparam int AW = $clog2(IW * IH);
    localparam int KW = $clog2(IW);

    typedef struct packed {
        logic [NU-1:0]          m;
        logic [NU-1:0][AW-1:0]  a;
        logic [NU-1:0][DW-1:0]  d;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   start = 1'b0;
    logic [KW-1:0]          kernel_dim = '0;
    logic [AW-1:0]          base_addr = '0;
    logic                   relu_en = 1'b0;
    logic                   en_in = 1'b0;
    logic [NU-1:0][DW-1:0]  data_in = '0;
    logic                   in_ready;
    logic                   mem_stall = 1'b0;
    logic                   wr_en;
    logic [NU-1:0]          wr_mask;
    logic [NU-1:0][AW-1:0]  wr_addr;
    logic [NU-1:0][DW-1:0]  wr_data;
    logic                   busy;
    logic                   done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    output_writeback #(
        .DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH), .NUM_UNITS(NU)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .kernel_dim(kernel_dim),
        .base_addr(base_addr), .relu_en(relu_en), .en_in(en_in), .data_in(data_in),
        .in_ready(in_ready), .mem_stall(mem_stall), .wr_en(wr_en), .wr_mask(wr_mask),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
    );

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; en_in = 1'b1; mem_stall = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({in_ready, wr_en, wr_mask, wr_addr, wr_data, busy, done} !== '0) begin
                errors++;
                $display("FAIL reset_outputs rdy=%b wr_en=%b mask=%b addr=%h data=%h busy=%b done=%b required all 0",
                         in_ready, wr_en, wr_mask, wr_addr, wr_data, busy, done);
            end
        end
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || wr_en !== 1'b0 || wr_addr !== '0) begin
            errors++;
            $display("FAIL idle_after_reset rdy=%b busy=%b wr_en=%b addr=%h required 0 0 0 0",
                     in_ready, busy, wr_en, wr_addr);
        end
        @(posedge clk); #1; en_in = 1'b0;
    endtask

    // One complete frame against a queue-based model of pending writes.
    // mode 0: continuous beats; mode 1: random en_in / mem_stall; mode 2: fixed lane data {-5, 7}.
    task automatic test_frame(input int k, input int base, input bit relu,
                              input int stall_at, input int stall_len, input int mode);
        int   kk, total, idx, beats, dones, phase;
        bit   st, exp_rdy, exp_wr;
        exp_t pend[$];
        exp_t e;
        kk    = (k == 0) ? 1 : k;
        total = (IW - kk + 1) * (IH - kk + 1);
        idx = 0; beats = 0; dones = 0;

        @(posedge clk); #1;
        start = 1'b1; kernel_dim = KW'(k); base_addr = AW'(base); relu_en = relu;
        en_in = 1'b0; mem_stall = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL start_cycle_idle busy=%b rdy=%b required 0 0", busy, in_ready);
        end
        phase = 1;  // 1 RUN, 2 DRAIN, 3 DONE, 0 back in IDLE

        for (int cyc = 0; cyc < 600 && phase != 0; cyc++) begin
            @(posedge clk); #1;
            start      = (mode == 1) ? 1'($urandom_range(1)) : 1'b0;
            kernel_dim = KW'($urandom);
            base_addr  = AW'($urandom);
            relu_en    = 1'($urandom);
            st = (cyc >= stall_at && cyc < stall_at + stall_len) ||
                 (mode == 1 && $urandom_range(3) == 0);
            mem_stall = st;
            en_in     = (mode == 1) ? ($urandom_range(2) != 0) : 1'b1;
            for (int i = 0; i < NU; i++) data_in[i] = DW'($urandom);
            if (mode == 2) begin
                data_in[0] = 16'hFFFB;
                data_in[1] = 16'd7;
            end
            @(negedge clk);
            exp_rdy = (phase == 1) && (pend.size() < 2);
            exp_wr  = (pend.size() > 0) && !st;
            checks++;
            if (in_ready !== exp_rdy || wr_en !== exp_wr) begin
                errors++;
                $display("FAIL handshake k=%0d cyc=%0d rdy=%b wr_en=%b required %b %b",
                         k, cyc, in_ready, wr_en, exp_rdy, exp_wr);
            end
            checks++;
            if (busy !== (phase == 1 || phase == 2) || done !== (phase == 3)) begin
                errors++;
                $display("FAIL status k=%0d cyc=%0d busy=%b done=%b required %b %b",
                         k, cyc, busy, done, (phase == 1 || phase == 2), (phase == 3));
            end
            if (exp_wr && wr_en === 1'b1) begin
                checks++;
                if (wr_mask !== pend[0].m || wr_addr !== pend[0].a || wr_data !== pend[0].d) begin
                    errors++;
                    $display("FAIL write k=%0d cyc=%0d mask=%b addr=%h data=%h required %b %h %h",
                             k, cyc, wr_mask, wr_addr, wr_data, pend[0].m, pend[0].a, pend[0].d);
                end
            end else begin
                checks++;
                if (wr_mask !== '0) begin
                    errors++;
                    $display("FAIL idle_mask cyc=%0d mask=%b required 0", cyc, wr_mask);
                end
            end

            if (exp_wr) void'(pend.pop_front());
            if (phase == 3) begin
                dones++;
                phase = 0;
            end else if (phase == 2) begin
                if (pend.size() == 0) phase = 3;
            end else if (en_in && exp_rdy) begin
                e = '0;
                for (int i = 0; i < NU; i++) begin
                    e.m[i] = (idx + i) < total;
                    e.a[i] = AW'((base + idx + i) % (1 << AW));
                    e.d[i] = (relu && $signed(data_in[i]) < 0) ? '0 : data_in[i];
                end
                pend.push_back(e);
                idx += NU;
                beats++;
                if (idx >= total) phase = 2;
            end
        end

        checks++;
        if (phase != 0) begin
            errors++;
            $display("FAIL frame_timeout k=%0d phase=%0d required completion within 600 cycles", k, phase);
        end
        checks++;
        if (beats != (total + NU - 1) / NU || dones != 1) begin
            errors++;
            $display("FAIL frame_totals k=%0d beats=%0d dones=%0d required %0d 1",
                     k, beats, dones, (total + NU - 1) / NU);
        end
        @(posedge clk); #1; start = 1'b0; en_in = 1'b1; mem_stall = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL back_to_idle rdy=%b busy=%b done=%b wr_en=%b required 0 0 0 0",
                     in_ready, busy, done, wr_en);
        end
        en_in = 1'b0;
    endtask

    task automatic test_reset_midframe();
        @(posedge clk); #1;
        start = 1'b1; kernel_dim = 3; base_addr = 10; relu_en = 1'b0; en_in = 1'b0; mem_stall = 1'b0;
        @(posedge clk); #1;                       // push idx 0 while stalled
        start = 1'b0; en_in = 1'b1; mem_stall = 1'b1; data_in = {16'd2, 16'd1};
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_first_ready rdy=%b required 1", in_ready);
        end
        @(posedge clk); #1;                       // start during RUN must be ignored
        start = 1'b1; base_addr = 40; kernel_dim = 5; en_in = 1'b0; mem_stall = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || wr_en !== 1'b0) begin
            errors++; $display("FAIL mid_start_ignored busy=%b wr_en=%b required 1 0", busy, wr_en);
        end
        @(posedge clk); #1;                       // second push fills the buffer
        start = 1'b0; en_in = 1'b1; mem_stall = 1'b1; data_in = {16'd4, 16'd3};
        @(posedge clk); #1;
        en_in = 1'b1; mem_stall = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || wr_en !== 1'b1 || wr_addr[0] !== AW'(10) || wr_data[0] !== 16'd1) begin
            errors++;
            $display("FAIL mid_full_pop rdy=%b wr_en=%b addr0=%0d data0=%0d required 0 1 10 1",
                     in_ready, wr_en, wr_addr[0], wr_data[0]);
        end
        @(posedge clk); #1;
        en_in = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b1 || wr_addr[0] !== AW'(12) || wr_addr[1] !== AW'(13)) begin
            errors++;
            $display("FAIL mid_second_write wr_en=%b addr=%0d,%0d required 1 12,13",
                     wr_en, wr_addr[0], wr_addr[1]);
        end
        @(posedge clk); #1;                       // leave exactly one entry buffered
        en_in = 1'b1; mem_stall = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || wr_en !== 1'b0) begin
            errors++; $display("FAIL mid_third_push rdy=%b wr_en=%b required 1 0", in_ready, wr_en);
        end
        @(posedge clk); #1;
        reset = 1'b0; en_in = 1'b0; mem_stall = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, wr_en, wr_mask, wr_addr, wr_data, busy, done} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs rdy=%b wr_en=%b mask=%b addr=%h data=%h busy=%b done=%b required all 0",
                     in_ready, wr_en, wr_mask, wr_addr, wr_data, busy, done);
        end
        @(posedge clk); #1;
        reset = 1'b1; en_in = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (wr_en !== 1'b0 || wr_mask !== '0 || in_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL mid_after_reset c=%0d wr_en=%b mask=%b rdy=%b busy=%b done=%b required 0",
                         c, wr_en, wr_mask, in_ready, busy, done);
            end
        end
        @(posedge clk); #1; en_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame(3, 0, 1'b0, 1000, 0, 0);   // TOTAL 36, 18 beats
        test_frame(2, 0, 1'b0, 1000, 0, 0);   // TOTAL 49, last write mask 01 at 48
        test_frame(3, 0, 1'b0, 6, 5, 0);      // 5-cycle stall mid-frame
        test_frame(3, 0, 1'b1, 1000, 0, 2);   // relu on: {-5,7} -> {0,7}
        test_frame(3, 0, 1'b0, 1000, 0, 2);   // relu off: unchanged
        test_frame(7, 60, 1'b0, 1000, 0, 0);  // TOTAL 4 at 60..63
        test_frame(7, 62, 1'b0, 1000, 0, 0);  // address wrap 62,63,0,1
        test_frame(0, 5, 1'b0, 1000, 0, 0);   // k=0 behaves as k=1
        test_reset_midframe();
        test_frame(3, 0, 1'b0, 1000, 0, 0);   // fresh frame after mid-frame reset
        for (int r = 0; r < 6; r++) begin
            test_frame($urandom_range(7), $urandom_range(63), 1'($urandom_range(1)),
                       $urandom_range(20), $urandom_range(4), 1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
